ws2812_receiver: RTL and testbench
==================================

Name: ws2812_receiver

Overview:
- Decodes a WS2812-style single-wire serial LED stream back into 24-bit pixel words; it is the receive end of the LED transmit path.
- Used as an in-system monitor and as a loopback checker on the LED data pin of the Game of Life matrix driver.
- Runs on the 12 MHz system clock, where 15 cycles make one bit.
- Recovers each pixel MSB-first, tags it with its arrival index within the frame, and reports frame boundaries and framing errors.

Parameters:
- NUM_PIXELS, 64: pixels per frame; pixels beyond this count are dropped and flagged.
- BIT_THRESH, 7: a high pulse of at least BIT_THRESH synchronized cycles decodes as 1; a shorter one decodes as 0.
- MAX_HIGH, 14: a high pulse longer than MAX_HIGH cycles is a framing error.
- RESET_CYCLES, 600: continuous low for this many cycles (50 us) is the latch/reset gap that ends a frame.

Ports:
- clk  in  1  system clock, 12 MHz, all logic on posedge.
- rst  in  1  synchronous active-high reset.
- din  in  1  asynchronous serial LED data line.
- pixel_data  out  24  last complete pixel; first-received bit in bit 23.
- pixel_index  out  6  arrival index of pixel_data within its frame, 0-based.
- pixel_valid  out  1  one-cycle strobe: pixel_data and pixel_index are updated this cycle.
- frame_done  out  1  one-cycle strobe when the latch gap ends a frame.
- frame_pixels  out  7  pixels received in the just-ended frame, saturating at NUM_PIXELS; valid with frame_done.
- overflow  out  1  sticky: a frame contained more than NUM_PIXELS pixels; cleared only by rst.
- frame_err  out  1  one-cycle strobe on a framing error.

Behaviour:
- Synchronizer:
  - din passes through a 2-flop synchronizer to give din_s; a third flop holds din_d.
  - rise = din_s & ~din_d; fall = ~din_s & din_d.
  - All timing counts below are in synchronized-sample cycles.
- Reset:
  - All outputs 0 and all counters 0.
  - State goes to SYNC.
  - pixel_data and pixel_index hold 0 until the first pixel.
- States:
  - SYNC: waits for RESET_CYCLES consecutive low samples before accepting data, so the block never locks onto a frame mid-stream. Any high sample clears the low counter. When the count is reached, go to IDLE. No frame_done is issued from SYNC.
  - IDLE: line low, between frames. On rise: clear the high counter and go to HIGH.
  - HIGH: increment the high counter each cycle din_s = 1.
    - If the counter exceeds MAX_HIGH: pulse frame_err, discard the partial pixel, go to SYNC.
    - On fall: decode the bit (counter >= BIT_THRESH gives 1), shift it into the 24-bit shift register, increment the bit counter, clear the low counter, go to LOW.
  - LOW: increment the low counter.
    - On rise: go to HIGH.
    - When the low counter reaches RESET_CYCLES, the frame ends:
      - If the bit counter is 0: pulse frame_done, drive frame_pixels, clear the pixel counter, go to IDLE.
      - If the bit counter is nonzero (partial pixel): pulse frame_err (no frame_done), discard the partial pixel, clear the pixel counter, go to IDLE.
- Pixel assembly:
  - When the fall that completes bit 24 is decoded, pixel_valid is asserted on the next clock edge.
  - With it, pixel_data = the shift register (including the new bit) and pixel_index = the pixel counter.
  - Then the pixel counter increments and the bit counter resets to 0.
  - Latency: pixel_valid appears 4 clk after the raw din falling edge (2 sync + 1 edge detect + 1 register).
- Overflow:
  - Pixel counter value NUM_PIXELS or above: pixel_valid is suppressed and overflow is set.
  - The counter saturates at NUM_PIXELS; frame_pixels reports NUM_PIXELS.
- Pulse timing:
  - frame_done, frame_err and pixel_valid are mutually exclusive in any cycle.
  - pixel_valid is always at least 2 cycles after the preceding frame_done.
- Boundary cases:
  - A high pulse of exactly BIT_THRESH decodes as 1; BIT_THRESH-1 decodes as 0.
  - A high pulse of exactly MAX_HIGH is legal.
  - A low gap of RESET_CYCLES-1 continues the frame.
  - Widths: high counter 4 bits minimum; low counter wide enough for RESET_CYCLES (10 bits at default).
- rst mid-frame: the shift register, bit counter and pixel counter clear immediately, and the block re-enters SYNC. Any in-flight pixel is discarded.

Test Plan:
- rst high 3 cycles, then din low 600 cycles, then frame 0xFF0000 (bit 1 = 10 high/5 low, bit 0 = 5 high/10 low), then 600 low -> pixel_valid once with pixel_data=0xFF0000, pixel_index=0; then frame_done with frame_pixels=1.
- 64 pixels, pixel i = {i,8'hA5,~i}, then latch gap -> 64 pixel_valid strobes with matching data, indices 0..63 in order; frame_done with frame_pixels=64; overflow=0.
- 66 pixels -> 64 pixel_valid strobes; overflow=1 stays high; frame_pixels=64; next frame still decodes normally.
- Bit high widths 6, 7, 14, 15 in successive tests -> decode 0, decode 1, decode 1, frame_err then no output until 600 low cycles.
- 12 bits then 600 low -> frame_err pulse, no pixel_valid, no frame_done; a following clean pixel decodes at index 0.
- Start din toggling mid-pixel right after reset with no preceding gap -> nothing decoded until the first 600-cycle low; assert rst during pixel 3 of a frame -> all outputs 0, next full frame decodes from index 0.

Source files
------------

// File: rtl/ws2812_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : ws2812_receiver
//  Description : Decodes a WS2812-style single-wire LED stream into 24-bit
//                pixel words tagged with their arrival index, and reports
//                frame boundaries, overflow and framing errors.
//  Revision    : 1.0 - initial release
// ============================================================================
module ws2812_receiver #(
    parameter int NUM_PIXELS   = 64,
    parameter int BIT_THRESH   = 7,
    parameter int MAX_HIGH     = 14,
    parameter int RESET_CYCLES = 600
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              din,
    output logic [23:0]                       pixel_data,
    output logic [$clog2(NUM_PIXELS)-1:0]     pixel_index,
    output logic                              pixel_valid,
    output logic                              frame_done,
    output logic [$clog2(NUM_PIXELS+1)-1:0]   frame_pixels,
    output logic                              overflow,
    output logic                              frame_err
);

    localparam int IDX_W  = $clog2(NUM_PIXELS);
    localparam int PCNT_W = $clog2(NUM_PIXELS + 1);
    localparam int LOW_W  = $clog2(RESET_CYCLES + 1);
    localparam int HIGH_W = $clog2(MAX_HIGH + 2);

    localparam logic [LOW_W-1:0]  LOW_LAST = LOW_W'(RESET_CYCLES - 1);
    localparam logic [HIGH_W-1:0] HIGH_MAX = HIGH_W'(MAX_HIGH);
    localparam logic [HIGH_W-1:0] THRESH   = HIGH_W'(BIT_THRESH);
    localparam logic [PCNT_W-1:0] PIX_MAX  = PCNT_W'(NUM_PIXELS);

    typedef enum logic [1:0] {
        ST_SYNC = 2'd0,
        ST_IDLE = 2'd1,
        ST_HIGH = 2'd2,
        ST_LOW  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                sync1_q, din_s_q, din_d_q;
    logic [LOW_W-1:0]    low_cnt_q, low_cnt_d;
    logic [HIGH_W-1:0]   high_cnt_q, high_cnt_d;
    logic [4:0]          bit_cnt_q, bit_cnt_d;
    logic [23:0]         shift_q, shift_d;
    logic [PCNT_W-1:0]   pix_cnt_q, pix_cnt_d;
    logic                pend_q, pend_d;
    logic [23:0]         pixel_data_q, pixel_data_d;
    logic [IDX_W-1:0]    pixel_index_q, pixel_index_d;
    logic                pixel_valid_q, pixel_valid_d;
    logic                frame_done_q, frame_done_d;
    logic [PCNT_W-1:0]   frame_pixels_q, frame_pixels_d;
    logic                overflow_q, overflow_d;
    logic                frame_err_q, frame_err_d;
    logic                w_rise;

    assign w_rise = din_s_q & ~din_d_q;

    // Two-flop synchronizer for the asynchronous line plus one delay flop for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            din_s_q <= 1'b0;
            din_d_q <= 1'b0;
        end else begin
            sync1_q <= din;
            din_s_q <= sync1_q;
            din_d_q <= din_s_q;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_SYNC;
            low_cnt_q      <= '0;
            high_cnt_q     <= '0;
            bit_cnt_q      <= '0;
            shift_q        <= '0;
            pix_cnt_q      <= '0;
            pend_q         <= 1'b0;
            pixel_data_q   <= '0;
            pixel_index_q  <= '0;
            pixel_valid_q  <= 1'b0;
            frame_done_q   <= 1'b0;
            frame_pixels_q <= '0;
            overflow_q     <= 1'b0;
            frame_err_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            low_cnt_q      <= low_cnt_d;
            high_cnt_q     <= high_cnt_d;
            bit_cnt_q      <= bit_cnt_d;
            shift_q        <= shift_d;
            pix_cnt_q      <= pix_cnt_d;
            pend_q         <= pend_d;
            pixel_data_q   <= pixel_data_d;
            pixel_index_q  <= pixel_index_d;
            pixel_valid_q  <= pixel_valid_d;
            frame_done_q   <= frame_done_d;
            frame_pixels_q <= frame_pixels_d;
            overflow_q     <= overflow_d;
            frame_err_q    <= frame_err_d;
        end
    end

    // Next-state logic: pulse measurement, bit decode, pixel emission and frame framing
    always_comb begin
        state_d        = state_q;
        low_cnt_d      = low_cnt_q;
        high_cnt_d     = high_cnt_q;
        bit_cnt_d      = bit_cnt_q;
        shift_d        = shift_q;
        pix_cnt_d      = pix_cnt_q;
        pend_d         = 1'b0;
        pixel_data_d   = pixel_data_q;
        pixel_index_d  = pixel_index_q;
        pixel_valid_d  = 1'b0;
        frame_done_d   = 1'b0;
        frame_pixels_d = frame_pixels_q;
        overflow_d     = overflow_q;
        frame_err_d    = 1'b0;

        // A pixel completed last cycle: publish it, or drop it once the frame is full
        if (pend_q) begin
            if (pix_cnt_q < PIX_MAX) begin
                pixel_valid_d = 1'b1;
                pixel_data_d  = shift_q;
                pixel_index_d = pix_cnt_q[IDX_W-1:0];
                pix_cnt_d     = pix_cnt_q + 1'b1;
            end else begin
                overflow_d = 1'b1;
            end
        end

        unique case (state_q)
            ST_SYNC: begin
                if (din_s_q) begin
                    low_cnt_d = '0;
                end else if (low_cnt_q == LOW_LAST) begin
                    low_cnt_d = '0;
                    state_d   = ST_IDLE;
                end else begin
                    low_cnt_d = low_cnt_q + 1'b1;
                end
            end
            ST_IDLE: begin
                // The rising sample itself is the first high cycle of the pulse
                if (w_rise) begin
                    high_cnt_d = HIGH_W'(1);
                    state_d    = ST_HIGH;
                end
            end
            ST_HIGH: begin
                if (din_s_q) begin
                    if (high_cnt_q == HIGH_MAX) begin
                        frame_err_d = 1'b1;
                        bit_cnt_d   = '0;
                        shift_d     = '0;
                        pix_cnt_d   = '0;
                        low_cnt_d   = '0;
                        state_d     = ST_SYNC;
                    end else begin
                        high_cnt_d = high_cnt_q + 1'b1;
                    end
                end else begin
                    shift_d = {shift_q[22:0], (high_cnt_q >= THRESH)};
                    if (bit_cnt_q == 5'd23) begin
                        bit_cnt_d = '0;
                        pend_d    = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                    // The falling sample counts as the first low cycle of the gap
                    low_cnt_d = LOW_W'(1);
                    state_d   = ST_LOW;
                end
            end
            ST_LOW: begin
                if (w_rise) begin
                    high_cnt_d = HIGH_W'(1);
                    state_d    = ST_HIGH;
                end else if (low_cnt_q == LOW_LAST) begin
                    if (bit_cnt_q == '0) begin
                        frame_done_d   = 1'b1;
                        frame_pixels_d = pix_cnt_q;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                    bit_cnt_d = '0;
                    shift_d   = '0;
                    pix_cnt_d = '0;
                    low_cnt_d = '0;
                    state_d   = ST_IDLE;
                end else begin
                    low_cnt_d = low_cnt_q + 1'b1;
                end
            end
            default: state_d = ST_SYNC;
        endcase
    end

    assign pixel_data   = pixel_data_q;
    assign pixel_index  = pixel_index_q;
    assign pixel_valid  = pixel_valid_q;
    assign frame_done   = frame_done_q;
    assign frame_pixels = frame_pixels_q;
    assign overflow     = overflow_q;
    assign frame_err    = frame_err_q;

endmodule
`default_nettype wire

// File: tb/tb_ws2812_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ws2812_receiver
//  Description : Self-checking bench for ws2812_receiver with a pulse-level
//                reference model of the decoded pixel and frame stream.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ws2812_receiver;

    localparam int NUM_PIXELS   = 64;
    localparam int BIT_THRESH   = 7;
    localparam int MAX_HIGH     = 14;
    localparam int RESET_CYCLES = 600;

    logic        clk = 1'b0;
    logic        rst;
    logic        din;
    logic [23:0] pixel_data;
    logic [5:0]  pixel_index;
    logic        pixel_valid;
    logic        frame_done;
    logic [6:0]  frame_pixels;
    logic        overflow;
    logic        frame_err;

    ws2812_receiver dut (
        .clk          (clk),
        .rst          (rst),
        .din          (din),
        .pixel_data   (pixel_data),
        .pixel_index  (pixel_index),
        .pixel_valid  (pixel_valid),
        .frame_done   (frame_done),
        .frame_pixels (frame_pixels),
        .overflow     (overflow),
        .frame_err    (frame_err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int last_fall = 0;
    int valid_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Observed events
    logic [29:0] obs_pix[$];
    int          obs_done[$];
    int          obs_err = 0;

    // Reference model state
    logic [29:0] exp_pix[$];
    int          exp_done[$];
    int          exp_err = 0;
    bit          m_sync, m_active, m_fired, m_ovf;
    int          m_cnt, m_bits, m_low;
    logic [23:0] m_word;

    // Monitor: collect strobes and check they never overlap
    always @(negedge clk) begin
        if (!rst) begin
            if (pixel_valid | frame_done | frame_err) begin
                checks++;
                assert ($countones({pixel_valid, frame_done, frame_err}) === 1) else begin
                    failures++;
                    $error("FAIL strobe_exclusive observed=%b expected=onehot",
                           {pixel_valid, frame_done, frame_err});
                end
            end
            if (pixel_valid) begin
                obs_pix.push_back({pixel_index, pixel_data});
                valid_cyc = cyc;
            end
            if (frame_done) obs_done.push_back(int'(frame_pixels));
            if (frame_err)  obs_err++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic model_reset();
        m_sync = 0; m_active = 0; m_fired = 0; m_ovf = 0;
        m_cnt = 0; m_bits = 0; m_low = 0; m_word = '0;
        exp_pix.delete(); exp_done.delete(); exp_err = 0;
        obs_pix.delete(); obs_done.delete(); obs_err = 0;
    endtask

    // A high pulse of hi cycles as seen by the protocol rules
    task automatic model_high(input int hi);
        m_low = 0;
        m_fired = 0;
        if (m_sync) begin
            m_active = 1;
            if (hi > MAX_HIGH) begin
                exp_err++;
                m_sync = 0; m_active = 0; m_bits = 0; m_cnt = 0;
            end else begin
                m_word = {m_word[22:0], (hi >= BIT_THRESH)};
                m_bits++;
                if (m_bits == 24) begin
                    m_bits = 0;
                    if (m_cnt < NUM_PIXELS) begin
                        exp_pix.push_back({6'(m_cnt), m_word});
                        m_cnt++;
                    end else begin
                        m_ovf = 1;
                    end
                end
            end
        end
    endtask

    // A low run extension of n cycles
    task automatic model_low(input int n);
        m_low += n;
        if (m_low >= RESET_CYCLES && !m_fired) begin
            m_fired = 1;
            if (!m_sync) begin
                m_sync = 1;
            end else if (m_active) begin
                if (m_bits == 0) exp_done.push_back(m_cnt);
                else             exp_err++;
                m_bits = 0; m_cnt = 0; m_active = 0;
            end
        end
    endtask

    task automatic pulse(input int hi, input int lo);
        din = 1'b1;
        tick(hi);
        din = 1'b0;
        last_fall = cyc;
        tick(lo);
        model_high(hi);
        model_low(lo);
    endtask

    task automatic gap(input int n);
        din = 1'b0;
        tick(n);
        model_low(n);
    endtask

    task automatic rand_bit();
        if ($urandom_range(1, 0) == 1) pulse($urandom_range(14, 7), $urandom_range(6, 2));
        else                           pulse($urandom_range(6, 2), $urandom_range(6, 2));
    endtask

    task automatic tx_pixel(input logic [23:0] d, input bit fixed);
        for (int i = 23; i >= 0; i--) begin
            if (fixed)  pulse(d[i] ? 10 : 5, d[i] ? 5 : 10);
            else if (d[i]) pulse($urandom_range(14, 7), $urandom_range(6, 2));
            else           pulse($urandom_range(6, 2), $urandom_range(6, 2));
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        din = 1'b0;
        tick(3);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic cmp(input string tag);
        chk({tag, "_npix"}, obs_pix.size(), exp_pix.size());
        for (int i = 0; i < exp_pix.size() && i < obs_pix.size(); i++)
            chk({tag, "_pix"}, obs_pix[i], exp_pix[i]);
        chk({tag, "_ndone"}, obs_done.size(), exp_done.size());
        for (int i = 0; i < exp_done.size() && i < obs_done.size(); i++)
            chk({tag, "_frame_pixels"}, obs_done[i], exp_done[i]);
        chk({tag, "_nerr"}, obs_err, exp_err);
        exp_pix.delete(); exp_done.delete(); exp_err = 0;
        obs_pix.delete(); obs_done.delete(); obs_err = 0;
    endtask

    initial begin
        int wl[4];
        wl[0] = 6; wl[1] = 7; wl[2] = 14; wl[3] = 15;

        // Reset state
        do_reset();
        chk("rst_pixel_data",   pixel_data,   0);
        chk("rst_pixel_index",  pixel_index,  0);
        chk("rst_pixel_valid",  pixel_valid,  0);
        chk("rst_frame_done",   frame_done,   0);
        chk("rst_frame_pixels", frame_pixels, 0);
        chk("rst_overflow",     overflow,     0);
        chk("rst_frame_err",    frame_err,    0);
        gap(610);

        // Single fixed-timing pixel
        tx_pixel(24'hFF0000, 1'b1);
        gap(610);
        chk("latency", valid_cyc - last_fall, 4);
        cmp("basic");

        // Full frame of 64 patterned pixels
        for (int i = 0; i < 64; i++) tx_pixel({8'(i), 8'hA5, ~8'(i)}, 1'b0);
        gap(610);
        chk("full_overflow", overflow, 0);
        cmp("full64");

        // 66 pixels: two dropped, overflow sticky
        for (int i = 0; i < 66; i++) tx_pixel(24'($urandom), 1'b0);
        gap(610);
        chk("ovf_overflow", overflow, 1);
        cmp("ovf66");
        for (int i = 0; i < 2; i++) tx_pixel(24'($urandom), 1'b0);
        gap(610);
        chk("ovf_sticky", overflow, 1);
        cmp("after_ovf");

        // First-bit high widths around the threshold and the maximum
        for (int k = 0; k < 4; k++) begin
            pulse(wl[k], 4);
            for (int i = 0; i < 23; i++) rand_bit();
            gap(610);
            cmp($sformatf("width%0d", wl[k]));
        end
        tx_pixel(24'($urandom), 1'b0);
        gap(610);
        cmp("after_width_err");

        // Low gap one short of the latch gap keeps the frame going
        for (int i = 0; i < 10; i++) rand_bit();
        pulse(10, RESET_CYCLES - 1);
        for (int i = 0; i < 13; i++) rand_bit();
        gap(610);
        cmp("gap599");

        // Partial pixel at frame end
        for (int i = 0; i < 12; i++) rand_bit();
        gap(610);
        cmp("partial");
        tx_pixel(24'($urandom), 1'b0);
        gap(610);
        cmp("after_partial");

        // Mid-stream start right after reset
        do_reset();
        for (int i = 0; i < 30; i++) rand_bit();
        gap(610);
        cmp("midstream");
        tx_pixel(24'($urandom), 1'b0);
        gap(610);
        cmp("after_midstream");

        // Reset while pixel 3 is arriving
        for (int i = 0; i < 3; i++) tx_pixel(24'($urandom), 1'b0);
        for (int i = 0; i < 12; i++) rand_bit();
        cmp("pre_rst");
        do_reset();
        chk("midrst_pixel_data",   pixel_data,   0);
        chk("midrst_pixel_index",  pixel_index,  0);
        chk("midrst_overflow",     overflow,     0);
        chk("midrst_frame_pixels", frame_pixels, 0);
        gap(610);
        for (int i = 0; i < 4; i++) tx_pixel(24'($urandom), 1'b0);
        gap(610);
        cmp("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
